// File: rtl/bfloat16_rf_mp.sv
// rtl/bfloat16_rf_mp.sv - bfloat16 register file, one write port, two registered read ports
// Valid-tagged entries, per-port sign/denormal operators, sequential init sweep.
module bfloat16_rf_mp #(
   parameter int                DATA_W   = 16,
   parameter int                DEPTH    = 32,
   parameter int                ADDR_W   = $clog2(DEPTH),
   parameter logic [DATA_W-1:0] INIT_VAL = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_x,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re0,
   input  logic [ADDR_W-1:0] raddr0,
   input  logic [1:0]        rop0,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [1:0]        rop1,
   input  logic              init_start,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvld0,
   output logic              rhit0,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvld1,
   output logic              rhit1,
   output logic              busy,
   output logic              init_done,
   output logic              wr_drop
);

   typedef enum logic {S_IDLE, S_INIT} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                done_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DEPTH-1:0]    valid_q;
   logic [DATA_W-1:0]   rdata0_q, rdata1_q;
   logic                rvld0_q, rvld1_q, rhit0_q, rhit1_q;
   logic                init_done_q, wr_drop_q;
   logic                wr_acc, rd_ok;
   logic                byp0, byp1, hit0, hit1;
   logic [DATA_W-1:0]   word0, word1;

   // Operators assume the bfloat16 layout: sign[15], exp[14:7], mant[6:0].
   function automatic logic [DATA_W-1:0] apply_op(input logic [1:0] op, input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
      r = w;
      case (op)
         2'b01:   r = {1'b0, w[DATA_W-2:0]};
         2'b10:   r = {~w[DATA_W-1], w[DATA_W-2:0]};
         2'b11:   r = (w[14:7] == 8'd0) ? {w[DATA_W-1], {(DATA_W-1){1'b0}}} : w;
         default: r = w;
      endcase
      return r;
   endfunction

   assign wr_acc = we && (state_q == S_IDLE);
   assign rd_ok  = (state_q == S_IDLE);

   // Write-first bypass: an accepted write to the read address wins over storage.
   always_comb begin
      byp0  = wr_acc && (waddr == raddr0);
      byp1  = wr_acc && (waddr == raddr1);
      hit0  = byp0 || valid_q[raddr0];
      hit1  = byp1 || valid_q[raddr1];
      word0 = byp0 ? wdata : (valid_q[raddr0] ? mem_q[raddr0] : '0);
      word1 = byp1 ? wdata : (valid_q[raddr1] ? mem_q[raddr1] : '0);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (init_start) begin
               state_d = S_INIT;
               cnt_d   = '0;
            end
         end
         S_INIT: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_x) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         valid_q     <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         rvld0_q     <= 1'b0;
         rvld1_q     <= 1'b0;
         rhit0_q     <= 1'b0;
         rhit1_q     <= 1'b0;
         init_done_q <= 1'b0;
         wr_drop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= done_d;
         wr_drop_q   <= we && (state_q == S_INIT);
         if (wr_acc) valid_q[waddr] <= 1'b1;
         if (state_q == S_INIT) valid_q[cnt_q] <= 1'b1;
         rvld0_q <= re0 && rd_ok;
         rvld1_q <= re1 && rd_ok;
         if (re0 && rd_ok) begin
            rdata0_q <= apply_op(rop0, word0);
            rhit0_q  <= hit0;
         end
         if (re1 && rd_ok) begin
            rdata1_q <= apply_op(rop1, word1);
            rhit1_q  <= hit1;
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!rst_x) begin
         if (wr_acc) mem_q[waddr] <= wdata;
         if (state_q == S_INIT) mem_q[cnt_q] <= INIT_VAL;
      end
   end

   assign rdata0    = rdata0_q;
   assign rvld0     = rvld0_q;
   assign rhit0     = rhit0_q;
   assign rdata1    = rdata1_q;
   assign rvld1     = rvld1_q;
   assign rhit1     = rhit1_q;
   assign busy      = (state_q == S_INIT);
   assign init_done = init_done_q;
   assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_bfloat16_rf_mp.sv
// tb/tb_bfloat16_rf_mp.sv - self-checking bench for bfloat16_rf_mp
module tb_bfloat16_rf_mp;

   localparam int          DEPTH = 32;
   localparam logic [15:0] IVAL  = 16'h3F80;

   logic        clk = 0;
   logic        rst_x = 1;
   logic        we = 0, re0 = 0, re1 = 0, init_start = 0;
   logic [4:0]  waddr = 0, raddr0 = 0, raddr1 = 0;
   logic [15:0] wdata = 0;
   logic [1:0]  rop0 = 0, rop1 = 0;
   logic [15:0] rdata0, rdata1;
   logic        rvld0, rhit0, rvld1, rhit1, busy, init_done, wr_drop;

   bfloat16_rf_mp #(.DATA_W(16), .DEPTH(DEPTH), .INIT_VAL(IVAL)) dut (
      .clk(clk), .rst_x(rst_x), .we(we), .waddr(waddr), .wdata(wdata),
      .re0(re0), .raddr0(raddr0), .rop0(rop0),
      .re1(re1), .raddr1(raddr1), .rop1(rop1),
      .init_start(init_start),
      .rdata0(rdata0), .rvld0(rvld0), .rhit0(rhit0),
      .rdata1(rdata1), .rvld1(rvld1), .rhit1(rhit1),
      .busy(busy), .init_done(init_done), .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_mem [DEPTH];
   bit          m_val [DEPTH];
   int          init_left = 0;
   logic [15:0] e_rdata0 = 0, e_rdata1 = 0;
   bit          e_rvld0 = 0, e_rvld1 = 0, e_rhit0 = 0, e_rhit1 = 0;
   bit          e_busy = 0, e_done = 0, e_drop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] op_model(input logic [1:0] op, input logic [15:0] w);
      if (op == 2'd1) return w & 16'h7FFF;
      if (op == 2'd2) return w ^ 16'h8000;
      if (op == 2'd3 && ((w >> 7) & 16'hFF) == 0) return w & 16'h8000;
      return w;
   endfunction

   task automatic model_read(input logic [4:0] a, input logic [1:0] op,
                             output logic [15:0] d, output bit h);
      logic [15:0] w;
      bit accepted_wr;
      accepted_wr = we && init_left == 0;
      if (accepted_wr && waddr == a) begin w = wdata; h = 1; end
      else if (m_val[a]) begin w = m_mem[a]; h = 1; end
      else begin w = 16'h0000; h = 0; end
      d = op_model(op, w);
   endtask

   // Advance one clock: update the model from current inputs, then compare all outputs.
   task automatic cycle();
      bit was_busy;
      if (rst_x) begin
         for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
         init_left = 0;
         e_rdata0 = 0; e_rdata1 = 0; e_rvld0 = 0; e_rvld1 = 0;
         e_rhit0 = 0; e_rhit1 = 0; e_done = 0; e_drop = 0;
      end else begin
         was_busy = init_left > 0;
         e_drop = we && was_busy;
         e_done = 0;
         e_rvld0 = re0 && !was_busy;
         e_rvld1 = re1 && !was_busy;
         if (e_rvld0) model_read(raddr0, rop0, e_rdata0, e_rhit0);
         if (e_rvld1) model_read(raddr1, rop1, e_rdata1, e_rhit1);
         if (we && !was_busy) begin m_mem[waddr] = wdata; m_val[waddr] = 1; end
         if (was_busy) begin
            m_mem[DEPTH - init_left] = IVAL;
            m_val[DEPTH - init_left] = 1;
            init_left--;
            if (init_left == 0) e_done = 1;
         end else if (init_start) begin
            init_left = DEPTH;
         end
      end
      e_busy = init_left > 0;
      @(posedge clk);
      #1;
      chk("rvld0", rvld0, e_rvld0);
      chk("rvld1", rvld1, e_rvld1);
      chk("rdata0", rdata0, e_rdata0);
      chk("rdata1", rdata1, e_rdata1);
      chk("rhit0", rhit0, e_rhit0);
      chk("rhit1", rhit1, e_rhit1);
      chk("busy", busy, e_busy);
      chk("init_done", init_done, e_done);
      chk("wr_drop", wr_drop, e_drop);
   endtask

   task automatic idle_inputs();
      we = 0; re0 = 0; re1 = 0; init_start = 0; rst_x = 0;
      rop0 = 0; rop1 = 0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [15:0] d);
      idle_inputs(); we = 1; waddr = a; wdata = d; cycle();
   endtask

   task automatic rd0(input logic [4:0] a, input logic [1:0] op);
      idle_inputs(); re0 = 1; raddr0 = a; rop0 = op; cycle();
   endtask

   initial begin
      int n;
      rst_x = 1;
      cycle();
      cycle();
      chk("reset_busy", busy, 0);
      chk("reset_rvld0", rvld0, 0);

      // Reset contents read as invalid zero on both ports
      idle_inputs(); re0 = 1; re1 = 1; raddr0 = 5; raddr1 = 5; cycle();
      chk("t1_rdata0", rdata0, 16'h0000);
      chk("t1_rhit1", rhit1, 0);
      chk("t1_rvld1", rvld1, 1);

      for (int i = 0; i < DEPTH; i++) wr(5'(i), 16'h3F80 + 16'(i));
      idle_inputs(); re0 = 1; re1 = 1; raddr0 = 0; raddr1 = 31; cycle();
      chk("t2_rdata0", rdata0, 16'h3F80);
      chk("t2_rdata1", rdata1, 16'h3F9F);
      chk("t2_rhit", {rhit0, rhit1}, 2'b11);
      idle_inputs(); cycle();
      chk("t2_rvld_drop", rvld0, 0);
      chk("t2_hold", rdata1, 16'h3F9F);

      idle_inputs(); we = 1; waddr = 7; wdata = 16'h4049; re0 = 1; raddr0 = 7; cycle();
      chk("t3_bypass", rdata0, 16'h4049);
      chk("t3_bypass_hit", rhit0, 1);

      wr(1, 16'h3F80);
      rd0(1, 2'd1); chk("t4_abs", rdata0, 16'h3F80);
      rd0(1, 2'd2); chk("t4_neg", rdata0, 16'hBF80);
      wr(2, 16'h8012);
      rd0(2, 2'd3); chk("t4_ftz_denorm", rdata0, 16'h8000);
      wr(3, 16'h0080);
      rd0(3, 2'd3); chk("t4_ftz_norm", rdata0, 16'h0080);

      // Randomised traffic including occasional init sweeps and resets
      for (int k = 0; k < 600; k++) begin
         idle_inputs();
         we = ($urandom_range(0, 2) == 0);
         waddr = 5'($urandom); wdata = 16'($urandom);
         if ($urandom_range(0, 3) == 0) wdata[14:7] = 8'h00;
         re0 = $urandom_range(0, 1); raddr0 = 5'($urandom); rop0 = 2'($urandom);
         re1 = $urandom_range(0, 1); raddr1 = 5'($urandom); rop1 = 2'($urandom);
         if ($urandom_range(0, 3) == 0) raddr1 = raddr0;
         if ($urandom_range(0, 2) == 0) raddr0 = waddr;
         init_start = ($urandom_range(0, 60) == 0);
         rst_x = ($urandom_range(0, 250) == 0);
         cycle();
      end

      n = 0;
      while (init_left > 0 && n < 100) begin idle_inputs(); cycle(); n++; end
      chk("pre_sweep_idle", busy, 0);

      // Full sweep: length, dropped write, ignored restart, done pulse
      idle_inputs(); init_start = 1; cycle();
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         idle_inputs();
         if (n == 5) begin we = 1; waddr = 0; wdata = 16'h1234; end
         if (n == 12) init_start = 1;
         cycle();
         if (n == 5) chk("t5_wr_drop", wr_drop, 1);
      end
      chk("t5_busy_len", n, 32);
      chk("t5_init_done", init_done, 1);
      idle_inputs(); cycle();
      chk("t5_done_pulse", init_done, 0);
      rd0(0, 2'd0); chk("t5_rd0", rdata0, 16'h3F80); chk("t5_hit0", rhit0, 1);
      rd0(31, 2'd0); chk("t5_rd31", rdata0, 16'h3F80);

      // Reset in the middle of a sweep
      idle_inputs(); init_start = 1; cycle();
      for (int i = 0; i < 10; i++) begin idle_inputs(); cycle(); end
      idle_inputs(); rst_x = 1; cycle();
      chk("t6_busy", busy, 0);
      idle_inputs(); cycle();
      chk("t6_no_done", init_done, 0);
      for (int i = 0; i < DEPTH; i++) begin
         rd0(5'(i), 2'd0);
         if (i < 12) chk("t6_rhit", rhit0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bfloat16_rf_mp.md
Name: bfloat16_rf_mp

Overview:
Parametrised successor to the single-port bfloat16 register file. It has one write port and two independent read ports, each read with 1-cycle registered latency. Each entry carries a valid bit, and each read port has a bfloat16 sign/denormal output operator. A sequential init engine fills every entry with a programmable constant. The block sits between the load path and the bfloat16 datapath, serving two operands per cycle.

Parameters:
DATA_W, 16, entry width (bfloat16: sign[15], exp[14:7], mant[6:0]; operators assume this layout)
DEPTH, 32, number of entries, power of 2, >=2
ADDR_W, $clog2(DEPTH), address width
INIT_VAL, 16'h0000, value written by init engine

Ports:
clk  in  1  clock, all state on rising edge
rst_x  in  1  reset, synchronous, active-high
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
re0  in  1  read enable, port 0
raddr0  in  ADDR_W  read address, port 0
rop0  in  2  read operator, port 0
re1  in  1  read enable, port 1
raddr1  in  ADDR_W  read address, port 1
rop1  in  2  read operator, port 1
init_start  in  1  start init sweep (level sampled)
rdata0  out  DATA_W  registered read data, port 0
rvld0  out  1  rdata0 valid strobe
rhit0  out  1  addressed entry was valid
rdata1  out  DATA_W  registered read data, port 1
rvld1  out  1  rdata1 valid strobe
rhit1  out  1  addressed entry was valid
busy  out  1  init engine running
init_done  out  1  one-cycle pulse after sweep completes
wr_drop  out  1  one-cycle pulse: write rejected

Behaviour:
- Reset (rst_x=1 at posedge):
  - Clears all valid bits, state=IDLE, sweep counter=0.
  - Drives rdata0/1=0, rvld0/1=0, rhit0/1=0, busy=0, init_done=0, wr_drop=0.
  - Storage array is not cleared.
  - Reset overrides every other input. Reset during INIT aborts the sweep with no init_done.
- Write, in IDLE: we=1 at edge sets mem[waddr]<=wdata and valid[waddr]<=1.
- Write, in INIT: we=1 is ignored and wr_drop=1 in the next cycle.
- Read:
  - reX=1 at edge N gives rvldX=1 during cycle N+1, with rdataX=op(word) and rhitX=valid.
  - reX=0 gives rvldX=0. rdataX/rhitX hold their last values.
  - Invalid entry: word=16'h0000 and rhitX=0. The operator is still applied, so NEG yields 16'h8000.
- Bypass (write-first): same-edge write (accepted) and read to the same address return wdata with rhitX=1.
- Both ports may read the same or different addresses in the same cycle, independently.
- Reads while busy=1: ignored, rvldX=0.
- Operator rop:
  - 00 pass.
  - 01 ABS: bit15 forced to 0.
  - 10 NEG: bit15 inverted.
  - 11 FTZ: if exp==0, output {sign,15'b0}; else pass.
- FSM states: IDLE, INIT.
  - IDLE -> INIT: init_start=1 at edge T0. busy=1 from T0 onward.
  - INIT: at edge T0+1+i (i=0..DEPTH-1), mem[i]<=INIT_VAL and valid[i]<=1. The counter wraps only via the state exit.
  - INIT -> IDLE: at edge T0+DEPTH (last entry written). busy=0 and init_done=1 for exactly the following cycle.
  - init_start while INIT: ignored. Sweep length is always exactly DEPTH cycles.
- Simultaneous events in IDLE:
  - we and init_start together: the write commits at T0, then the sweep overwrites it.
  - re and init_start together: the read is served at T0+1.
- Sweep read-after-init: a read issued at edge T0+DEPTH+1 (the first IDLE edge) returns INIT_VAL.

Test Plan:
1. Reset, then read addr 5 on both ports -> rvld0=rvld1=1 one cycle later, rdata=16'h0000, rhit=0.
2. Write 32 entries addr i data 16'h3F80+i, then dual-read (0,31) -> rdata0=16'h3F80, rdata1=16'h3F9F, rhit=1, latency 1.
3. Same-cycle write addr 7 data 16'h4049 with re0 raddr0=7 -> rdata0=16'h4049, rhit0=1 (bypass).
4. Operators on stored 16'h3F80:
   - rop=01 -> 16'h3F80.
   - rop=10 -> 16'hBF80.
   - Stored 16'h8012 with rop=11 -> 16'h8000.
   - Stored 16'h0080 with rop=11 -> 16'h0080.
5. INIT_VAL=16'h3F80, pulse init_start:
   - busy=1 for exactly 32 cycles, then init_done=1 for 1 cycle.
   - A we during busy -> wr_drop=1 and no update.
   - Reads after the sweep return 16'h3F80, rhit=1.
   - A second init_start mid-sweep -> no extension.
6. Assert rst_x at sweep cycle 10 -> busy=0 and no init_done next cycle. All rhit=0 afterwards, including entries 0..9.
